// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake, ALU operand/result bus, writeback and debug signals
// shared between the op sequencer (slave) and its instruction source / ALU side (master).
interface alu_op_sequencer_if #(
  parameter int DW = 16
) ();
  logic          instr_valid;
  logic [15:0]   instr;
  logic          instr_ready;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_fs;
  logic [DW-1:0] alu_result;
  logic          wb_valid;
  logic [2:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          z_flag;
  logic          illegal;
  logic          busy;
  logic [2:0]    dbg_addr;
  logic [DW-1:0] dbg_data;

  modport slave (
    input  instr_valid, instr, alu_result, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_fs, wb_valid, wb_addr, wb_data,
           z_flag, illegal, busy, dbg_data
  );

  modport master (
    output instr_valid, instr, alu_result, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_fs, wb_valid, wb_addr, wb_data,
           z_flag, illegal, busy, dbg_data
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Three-state issue/writeback controller: accepts an instruction, reads operands
// from an 8x16 register file into the ALU, then writes the ALU result (or an LDI immediate) back.
module alu_op_sequencer #(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);

  localparam logic [3:0] OP_LDI = 4'b1001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2
  } state_t;

  state_t        state;
  logic [15:0]   ir;
  logic [DW-1:0] rf [NREGS];
  logic [DW-1:0] wr_val;

  function automatic logic is_reserved(input logic [3:0] op);
    return (op == 4'b1010) || (op == 4'b1101) || (op == 4'b1110);
  endfunction

  function automatic logic is_ldi(input logic [3:0] op);
    return op == OP_LDI;
  endfunction

  function automatic logic is_zero(input logic [DW-1:0] v);
    return v == '0;
  endfunction

  function automatic logic [DW-1:0] ldi_ext(input logic [8:0] imm);
    return {{(DW-9){1'b0}}, imm};
  endfunction

  // LDI bypasses the ALU entirely; everything else commits whatever the ALU produced.
  assign wr_val = is_ldi(ir[15:12]) ? ldi_ext(ir[8:0]) : bus.alu_result;

  assign bus.instr_ready = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.dbg_data    = rf[bus.dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ir           <= '0;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_fs   <= '0;
      bus.wb_valid <= 1'b0;
      bus.wb_addr  <= '0;
      bus.wb_data  <= '0;
      bus.z_flag   <= 1'b0;
      bus.illegal  <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      bus.wb_valid <= 1'b0;
      bus.illegal  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            ir    <= bus.instr;
            state <= DECODE;
          end
        end
        // Operand fetch; LDI and reserved opcodes leave the ALU inputs untouched.
        DECODE: begin
          if (!is_ldi(ir[15:12]) && !is_reserved(ir[15:12])) begin
            bus.alu_a  <= rf[ir[8:6]];
            bus.alu_b  <= rf[ir[5:3]];
            bus.alu_fs <= ir[15:12];
          end
          state <= EXECUTE;
        end
        // Writeback; the ALU has had a full cycle to settle on the registered operands.
        EXECUTE: begin
          if (is_reserved(ir[15:12])) begin
            bus.illegal <= 1'b1;
          end else begin
            rf[ir[11:9]] <= wr_val;
            bus.wb_data  <= wr_val;
            bus.wb_addr  <= ir[11:9];
            bus.wb_valid <= 1'b1;
            bus.z_flag   <= is_zero(wr_val);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle issue/writeback controller that drives the 16-bit ALU from the other side of its operand/function-select interface. It accepts 16-bit instructions over a valid/ready handshake and decodes each into a 4-bit function select plus operand reads from an internal 8x16 register file. It presents A, B and FS to the ALU, samples the ALU result, and writes it back while maintaining a registered zero flag. It sits between the instruction source (testbench or fetch unit) and the ALU.

Parameters:
NREGS, 8, register-file depth (index width fixed at 3 bits)
DW, 16, datapath width; must match ALU operand width

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction present on instr
instr  input  16  [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] ignored; LDI immediate = [8:0]
instr_ready  output  1  sequencer can accept; high only in IDLE
alu_a  output  16  registered operand A to ALU
alu_b  output  16  registered operand B to ALU
alu_fs  output  4  registered function select to ALU
alu_result  input  16  combinational ALU result
wb_valid  output  1  one-cycle pulse: writeback occurred
wb_addr  output  3  destination register of the writeback
wb_data  output  16  value written
z_flag  output  1  1 when the last written value == 0
illegal  output  1  one-cycle pulse: reserved opcode consumed
busy  output  1  state != IDLE
dbg_addr  input  3  debug read index
dbg_data  output  16  combinational rf[dbg_addr]

Behaviour:
- Reset (async, any state): state=IDLE; all 8 registers=0; alu_a=alu_b=0; alu_fs=0; wb_valid=0; wb_addr=0; wb_data=0; z_flag=0; illegal=0; busy=0; instr_ready=1. Reset mid-instruction aborts it with no writeback.
- States: IDLE -> DECODE -> EXECUTE -> IDLE. No other transitions.
- IDLE: instr_ready=1. On an edge with instr_valid=1: latch instr and go to DECODE. Otherwise stay in IDLE. instr is ignored when instr_ready=0.
- DECODE (1 cycle): alu_a<=rf[ra], alu_b<=rf[rb], alu_fs<=opcode. Exceptions: opcodes LDI (1001) and reserved (1010, 1101, 1110) leave alu_a, alu_b and alu_fs unchanged. Go to EXECUTE.
- EXECUTE (1 cycle): at the edge leaving EXECUTE:
  - ALU ops (0000-1000, 1011, 1100, 1111): wb_data<=alu_result; rf[rd]<=alu_result; wb_addr<=rd; wb_valid<=1 for one cycle; z_flag<=(alu_result==0).
  - LDI: value={7'b0,instr[8:0]}, written the same way as an ALU op; alu_result is ignored.
  - Reserved: no rf write; wb_valid stays 0; z_flag holds; illegal<=1 for one cycle.
  - Go to IDLE.
- Latency: instruction accepted at edge N; wb_valid/illegal high during the cycle after edge N+2. Next accept is possible at edge N+3. Throughput is 1 instruction per 3 cycles.
- Read-after-write: rf is written at edge N+2, before the next DECODE read at edge N+4 or later. No forwarding is needed, and a back-to-back dependent instruction sees the new value.
- rd == ra/rb is legal: the read happens at DECODE, the write at EXECUTE exit.
- All registers, including r0, are writable.
- wb_valid and illegal self-clear the following cycle. They are never high together.
- alu_a, alu_b and alu_fs hold their last values between instructions.
- dbg_data is combinational and reflects a write in the cycle after the write edge.
- Widths: all data is DW bits; results wrap modulo 2^16. The sequencer does no arithmetic of its own except the zero compare.

Test Plan:
- Reset, then LDI r1,#5 and LDI r2,#3 back-to-back -> each wb_valid 3 cycles after accept; dbg r1=0x0005, r2=0x0003; z_flag=0; instr_ready low for 2 cycles after each accept.
- ADD r3,r1,r2 (0x0650) -> alu_a=5, alu_b=3, alu_fs=0000 during EXECUTE; wb_addr=3, wb_data=0x0008, z_flag=0.
- SUB r4,r1,r1 -> wb_data=0x0000, z_flag=1. Then LDI r0,#0x1FF -> z_flag=0, r0=0x01FF.
- Wrap-around: LDI r5,#0x1FF, ADD r5,r5,r5 repeated until the result exceeds 0xFFFF -> the result is modulo 2^16, and z_flag=1 exactly when wb_data==0.
- Reserved opcode 1010 -> illegal pulses once, wb_valid=0, all registers unchanged, z_flag unchanged, alu_fs unchanged.
- Assert rst while in EXECUTE of ADD r6,... -> r6 stays 0, wb_valid never pulses, state=IDLE, instr_ready=1 immediately.
